// File: rtl/seg_frame_checker.sv
// rtl/seg_frame_checker.sv - debounces 7-segment digits HEX0..HEX3 into A, B, SUM and checks A+B==SUM.
module seg_frame_checker #(
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] SEG,
  input  logic [1:0] DIG,
  input  logic       seg_valid,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [7:0] SUM,
  output logic       frame_valid,
  output logic       sum_ok,
  output logic       illegal,
  output logic       seq_err
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_REPORT} state_t;

  localparam logic [3:0] STABLE_N = 4'(STABLE_CNT);

  state_t           state_q, state_d;
  logic [1:0]       exp_q, exp_d;
  logic [3:0]       run_q, run_d;
  logic [6:0]       last_seg_q, last_seg_d;
  logic [3:0][3:0]  nib_q, nib_d;
  logic [3:0]       ill_q, ill_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [7:0]       sum_q, sum_d;
  logic             sum_ok_q, sum_ok_d;
  logic             illegal_q, illegal_d;
  logic             seq_err_q, seq_err_d;

  logic [3:0]       dec_nib;
  logic             dec_ill;
  logic [3:0]       run_new;
  logic             start_run;
  logic             do_accept;
  logic [1:0]       acc_idx;
  logic [4:0]       ab_sum;

  // Active-low pattern lookup; anything outside the table decodes to 0 and flags illegal.
  always_comb begin
    dec_ill = 1'b0;
    dec_nib = 4'h0;
    case (SEG)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    run_d      = run_q;
    last_seg_d = last_seg_q;
    nib_d      = nib_q;
    ill_d      = ill_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    sum_ok_d   = sum_ok_q;
    illegal_d  = illegal_q;
    seq_err_d  = 1'b0;
    run_new    = 4'd1;
    start_run  = 1'b0;
    do_accept  = 1'b0;
    acc_idx    = exp_q;
    ab_sum     = 5'd0;

    case (state_q)
      S_IDLE: begin
        if (seg_valid && DIG == 2'd0) start_run = 1'b1;
      end
      S_CAPTURE: begin
        if (seg_valid) begin
          if (DIG == exp_q) begin
            run_new    = (run_q != 4'd0 && SEG == last_seg_q) ? run_q + 4'd1 : 4'd1;
            run_d      = run_new;
            last_seg_d = SEG;
            do_accept  = (run_new == STABLE_N);
          end else if (DIG == 2'd0) begin
            start_run = 1'b1;
          end else begin
            seq_err_d = 1'b1;
            state_d   = S_IDLE;
            exp_d     = 2'd0;
            run_d     = 4'd0;
          end
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A fresh digit-0 run, whether from IDLE or a mid-frame resync.
    if (start_run) begin
      state_d    = S_CAPTURE;
      exp_d      = 2'd0;
      run_d      = 4'd1;
      last_seg_d = SEG;
      acc_idx    = 2'd0;
      do_accept  = (STABLE_N == 4'd1);
    end

    if (do_accept) begin
      nib_d[acc_idx] = dec_nib;
      ill_d[acc_idx] = dec_ill;
      run_d          = 4'd0;
      exp_d          = acc_idx + 2'd1;
      if (acc_idx == 2'd3) begin
        state_d   = S_REPORT;
        a_d       = nib_d[0];
        b_d       = nib_d[1];
        sum_d     = {nib_d[3], nib_d[2]};
        ab_sum    = {1'b0, nib_d[0]} + {1'b0, nib_d[1]};
        illegal_d = |ill_d;
        sum_ok_d  = !(|ill_d) && (nib_d[3] <= 4'd1) && (sum_d == {3'b000, ab_sum});
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      exp_q      <= 2'd0;
      run_q      <= 4'd0;
      last_seg_q <= 7'd0;
      nib_q      <= '0;
      ill_q      <= 4'd0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      sum_q      <= 8'd0;
      sum_ok_q   <= 1'b0;
      illegal_q  <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      run_q      <= run_d;
      last_seg_q <= last_seg_d;
      nib_q      <= nib_d;
      ill_q      <= ill_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      sum_ok_q   <= sum_ok_d;
      illegal_q  <= illegal_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign SUM         = sum_q;
  assign frame_valid = (state_q == S_REPORT);
  assign sum_ok      = sum_ok_q;
  assign illegal     = illegal_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_seg_frame_checker.sv
// tb/tb_seg_frame_checker.sv - directed frame table plus corner-case sequences for seg_frame_checker.
module tb_seg_frame_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] SEG;
  logic [1:0] DIG;
  logic       seg_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] SUM;
  logic       frame_valid;
  logic       sum_ok;
  logic       illegal;
  logic       seq_err;

  int checks = 0;
  int errors = 0;

  seg_frame_checker #(.STABLE_CNT(3)) dut (
    .clk(clk), .reset(reset), .SEG(SEG), .DIG(DIG), .seg_valid(seg_valid),
    .A(A), .B(B), .SUM(SUM), .frame_valid(frame_valid), .sum_ok(sum_ok),
    .illegal(illegal), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] s0, s1, s2, s3;
    logic [3:0] a, b;
    logic [7:0] sum;
    logic       ok, ill;
  } frame_vec_t;

  frame_vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input logic [1:0] d, input logic [6:0] s);
    @(negedge clk);
    DIG = d; SEG = s; seg_valid = 1'b1;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [1:0] d, input logic [6:0] s);
    repeat (3) sample(d, s);
  endtask

  task automatic send_frame(input logic [6:0] s0, s1, s2, s3);
    send_digit(2'd0, s0);
    send_digit(2'd1, s1);
    send_digit(2'd2, s2);
    send_digit(2'd3, s3);
  endtask

  task automatic check_frame(input string tag, input logic [3:0] a, b, input logic [7:0] sum,
                             input logic ok, ill);
    check({tag, ".frame_valid"}, frame_valid, 1'b1);
    check({tag, ".A"}, A, a);
    check({tag, ".B"}, B, b);
    check({tag, ".SUM"}, SUM, sum);
    check({tag, ".sum_ok"}, sum_ok, ok);
    check({tag, ".illegal"}, illegal, ill);
  endtask

  initial begin
    vecs[0] = '{7'h79, 7'h40, 7'h79, 7'h40, 4'h1, 4'h0, 8'h01, 1'b1, 1'b0};
    vecs[1] = '{7'h0E, 7'h0E, 7'h06, 7'h79, 4'hF, 4'hF, 8'h1E, 1'b1, 1'b0};
    vecs[2] = '{7'h12, 7'h78, 7'h00, 7'h40, 4'h5, 4'h7, 8'h08, 1'b0, 1'b0};
    vecs[3] = '{7'h30, 7'h7F, 7'h30, 7'h40, 4'h3, 4'h0, 8'h03, 1'b0, 1'b1};
    vecs[4] = '{7'h10, 7'h00, 7'h79, 7'h79, 4'h9, 4'h8, 8'h11, 1'b1, 1'b0};
    vecs[5] = '{7'h00, 7'h00, 7'h40, 7'h79, 4'h8, 4'h8, 8'h10, 1'b1, 1'b0};
    vecs[6] = '{7'h08, 7'h03, 7'h12, 7'h79, 4'hA, 4'hB, 8'h15, 1'b1, 1'b0};
    vecs[7] = '{7'h46, 7'h21, 7'h10, 7'h79, 4'hC, 4'hD, 8'h19, 1'b1, 1'b0};

    SEG = 7'h7F; DIG = 2'd0; seg_valid = 1'b0; reset = 1'b1;
    #3;
    check("rst.A", A, 4'h0);
    check("rst.B", B, 4'h0);
    check("rst.SUM", SUM, 8'h00);
    check("rst.frame_valid", frame_valid, 1'b0);
    check("rst.sum_ok", sum_ok, 1'b0);
    check("rst.illegal", illegal, 1'b0);
    check("rst.seq_err", seq_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    sample(2'd1, 7'h79);
    check("idle_ignore.seq_err", seq_err, 1'b0);
    idle(1);
    check("idle_ignore.frame_valid", frame_valid, 1'b0);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3);
      check_frame($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].ok, vecs[i].ill);
      idle(1);
      check($sformatf("vec%0d.pulse_end", i), frame_valid, 1'b0);
    end

    // Unstable 8 then stable 5 on digit 0.
    sample(2'd0, 7'h00);
    sample(2'd0, 7'h00);
    send_digit(2'd0, 7'h12);
    send_digit(2'd1, 7'h24);
    send_digit(2'd2, 7'h78);
    send_digit(2'd3, 7'h40);
    check_frame("debounce", 4'h5, 4'h2, 8'h07, 1'b1, 1'b0);
    idle(1);

    send_digit(2'd0, 7'h02);
    sample(2'd2, 7'h24);
    check("skip.seq_err", seq_err, 1'b1);
    check("skip.frame_valid", frame_valid, 1'b0);
    check("skip.A_held", A, 4'h5);
    check("skip.SUM_held", SUM, 8'h07);
    idle(1);
    check("skip.seq_err_pulse", seq_err, 1'b0);

    // Digit 0 with seg_valid gaps inside the run.
    sample(2'd0, 7'h02);
    idle(2);
    sample(2'd0, 7'h02);
    sample(2'd0, 7'h02);
    send_digit(2'd1, 7'h24);
    send_digit(2'd2, 7'h00);
    send_digit(2'd3, 7'h40);
    check_frame("after_skip", 4'h6, 4'h2, 8'h08, 1'b1, 1'b0);

    // Sample in REPORT must not count toward the next digit-0 run.
    sample(2'd0, 7'h40);
    sample(2'd0, 7'h40);
    sample(2'd0, 7'h40);
    sample(2'd1, 7'h79);
    check("report_ignore.seq_err", seq_err, 1'b1);
    idle(1);

    send_digit(2'd0, 7'h79);
    send_digit(2'd1, 7'h40);
    sample(2'd0, 7'h24);
    check("resync.seq_err", seq_err, 1'b0);
    sample(2'd0, 7'h24);
    sample(2'd0, 7'h24);
    send_digit(2'd1, 7'h79);
    sample(2'd1, 7'h79);
    check("dup.seq_err", seq_err, 1'b1);
    check("dup.A_held", A, 4'h6);
    idle(1);

    send_frame(7'h24, 7'h79, 7'h30, 7'h40);
    check_frame("post_dup", 4'h2, 4'h1, 8'h03, 1'b1, 1'b0);
    idle(1);

    send_digit(2'd0, 7'h19);
    send_digit(2'd1, 7'h79);
    send_digit(2'd2, 7'h12);
    #2;
    reset = 1'b1;
    #1;
    check("midrst.A", A, 4'h0);
    check("midrst.B", B, 4'h0);
    check("midrst.SUM", SUM, 8'h00);
    check("midrst.sum_ok", sum_ok, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample(2'd3, 7'h40);
      check($sformatf("midrst.no_frame%0d", k), frame_valid, 1'b0);
    end
    idle(1);
    check("midrst.no_frame_end", frame_valid, 1'b0);
    check("midrst.seq_err", seq_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_frame_checker.md
SEG_FRAME_CHECKER -- requirements
Module: seg_frame_checker

Interface
REQ-001 Parameter STABLE_CNT, default 3: consecutive identical samples required to accept a digit; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 SEG  input  7  active-low segment pattern of one display digit; bit0=a ... bit6=g.
REQ-005 DIG  input  2  digit index of SEG: 0=HEX0 (operand A), 1=HEX1 (operand B), 2=HEX2 (sum low nibble), 3=HEX3 (sum high nibble).
REQ-006 seg_valid  input  1  SEG/DIG are sampled only in cycles where this is 1.
REQ-007 A  output  4  decoded operand from digit 0.
REQ-008 B  output  4  decoded operand from digit 1.
REQ-009 SUM  output  8  decoded {digit3, digit2}.
REQ-010 frame_valid  output  1  one-cycle pulse: a complete frame was captured.
REQ-011 sum_ok  output  1  frame is arithmetically consistent; meaningful when frame_valid=1, held until the next frame.
REQ-012 illegal  output  1  at least one digit of the last frame had a non-table pattern.
REQ-013 seq_err  output  1  one-cycle pulse: digit arrived out of order.

Function
REQ-014 Decode table (active-low), any other pattern is illegal and decodes to 0: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-015 FSM states: IDLE (expect digit 0, nothing captured), CAPTURE (expect digit k, k=0..3), REPORT (one cycle).
REQ-016 Stability: counter holds run length of identical SEG with DIG==expected; a sample whose SEG differs from the previous run restarts the run at 1 with the new pattern.
REQ-017 A digit is accepted on the sample that brings the run to STABLE_CNT; its decoded nibble and illegal bit are latched, expected index increments, and the run clears.
REQ-018 IDLE: a valid sample with DIG=0 enters CAPTURE with run=1 (accepted immediately if STABLE_CNT=1); samples with DIG!=0 are ignored, no seq_err.
REQ-019 CAPTURE, sample with DIG!=expected: if DIG=0, resynchronise (discard partial frame, expected=0, run=1 with this SEG), no seq_err; otherwise pulse seq_err next cycle and return to IDLE.
REQ-020 Samples with DIG equal to an already-accepted index also count as out-of-order per REQ-019.
REQ-021 Acceptance of digit 3 moves to REPORT; in REPORT, frame_valid=1 and A, B, SUM, sum_ok, illegal update in the same cycle (latency: one cycle after the accepting sample); next state IDLE.
REQ-022 sum_ok = 1 iff no digit illegal, digit3 <= 1, and SUM == A + B computed in 5 bits zero-extended.
REQ-023 A seg_valid sample in the REPORT cycle is ignored.
REQ-024 A, B, SUM, sum_ok, illegal hold their values between frames; a partial or aborted frame never changes them.
REQ-025 seg_valid=0 cycles neither advance nor break a run.

Reset
REQ-026 reset asserted: state IDLE, run=0, expected=0, all captured nibbles 0; A=0, B=0, SUM=0, frame_valid=0, sum_ok=0, illegal=0, seq_err=0, immediately and independent of clk.
REQ-027 Reset mid-frame discards the partial frame; the first post-release sample is treated as in IDLE.

Verification
REQ-028 STABLE_CNT=3; digits 0..3 each 3 samples: 1111001, 1000000, 1111001, 1000000 -> frame_valid pulse, A=1, B=0, SUM=0x01, sum_ok=1, illegal=0.
REQ-029 Digits 0001110, 0001110, 0000110, 1111001 (15+15) -> A=F, B=F, SUM=0x1E, sum_ok=1; digits 5,7,8,0 (SUM=0x08) -> sum_ok=0.
REQ-030 Digit 0 samples 0000000, 0000000, 0010010, 0010010, 0010010 -> A captured as 5, not 8; frame otherwise 5+2=07 -> sum_ok=1.
REQ-031 Digit 0 accepted, then valid sample DIG=2 -> seq_err one-cycle pulse, no frame_valid, outputs unchanged; following full frame 6+2=08 reports normally.
REQ-032 Digit 1 pattern 1111111 held 3 samples, rest consistent -> illegal=1, B=0, sum_ok=0.
REQ-033 reset pulsed after digit 2 accepted -> all outputs 0 immediately; remaining digit 3 samples produce no frame_valid.
